// File: rtl/fft_bin_sequencer_pkg.sv
// Shared types for the FFT bin sequencer.
// Frame-tracking FSM states.
package fft_bin_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SKIP    = 2'd2
  } state_t;

  function automatic int unsigned level_max(
    input int unsigned w
  );
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/fft_bin_sequencer_energy.sv
// Two-stage bin energy pipeline: square, sum, shift, saturate.
// Bin index and last flag ride along with the data.
module bin_energy_sat
  import fft_bin_sequencer_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int SHIFT = 6,
  parameter int OUT_W = 8,
  parameter int IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_flush,
  input  logic                    i_valid,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic                    i_last,
  input  logic signed [WIDTH-1:0] i_real,
  input  logic signed [WIDTH-1:0] i_imag,
  output logic                    o_valid,
  output logic [IDX_W-1:0]        o_idx,
  output logic                    o_last,
  output logic [OUT_W-1:0]        o_lvl
);

  localparam int SQ_W = 2 * WIDTH;
  localparam logic [SQ_W:0] LVL_MAX =
    (SQ_W+1)'(level_max(OUT_W));

  logic signed [SQ_W-1:0] w_re_ext;
  logic signed [SQ_W-1:0] w_im_ext;
  logic [SQ_W-1:0]        w_re_sq;
  logic [SQ_W-1:0]        w_im_sq;
  logic [SQ_W:0]          w_sum;
  logic [SQ_W:0]          w_e;
  logic [OUT_W-1:0]       w_lvl;

  logic                   r_s1_v;
  logic [IDX_W-1:0]       r_s1_idx;
  logic                   r_s1_last;
  logic [SQ_W-1:0]        r_s1_re;
  logic [SQ_W-1:0]        r_s1_im;

  logic                   r_s2_v;
  logic [IDX_W-1:0]       r_s2_idx;
  logic                   r_s2_last;
  logic [OUT_W-1:0]       r_s2_lvl;

  assign w_re_ext = SQ_W'(i_real);
  assign w_im_ext = SQ_W'(i_imag);
  assign w_re_sq  = $unsigned(w_re_ext * w_re_ext);
  assign w_im_sq  = $unsigned(w_im_ext * w_im_ext);

  assign w_sum = {1'b0, r_s1_re} + {1'b0, r_s1_im};
  assign w_e   = w_sum >> SHIFT;
  assign w_lvl = (w_e > LVL_MAX) ? '1 : w_e[OUT_W-1:0];

  // A flush kills the old frame in stage 1 while stage 1 loads the new bin 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_v    <= 1'b0;
      r_s1_idx  <= '0;
      r_s1_last <= 1'b0;
      r_s1_re   <= '0;
      r_s1_im   <= '0;
      r_s2_v    <= 1'b0;
      r_s2_idx  <= '0;
      r_s2_last <= 1'b0;
      r_s2_lvl  <= '0;
    end else begin
      r_s1_v <= i_valid;
      if (i_valid) begin
        r_s1_idx  <= i_idx;
        r_s1_last <= i_last;
        r_s1_re   <= w_re_sq;
        r_s1_im   <= w_im_sq;
      end
      r_s2_v <= r_s1_v & ~i_flush;
      if (r_s1_v) begin
        r_s2_idx  <= r_s1_idx;
        r_s2_last <= r_s1_last;
        r_s2_lvl  <= w_lvl;
      end
    end
  end

  assign o_valid = r_s2_v;
  assign o_idx   = r_s2_idx;
  assign o_last  = r_s2_last;
  assign o_lvl   = r_s2_lvl;

endmodule

// File: rtl/fft_bin_sequencer.sv
// FFT frame controller: captures the first BINS bins per frame,
// peak-holds their energy and publishes one coherent level set per frame.
module fft_bin_sequencer
  import fft_bin_sequencer_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int BINS  = 8,
  parameter int SHIFT = 6,
  parameter int OUT_W = 8,
  parameter int DECAY = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_ce,
  input  logic                    i_sync,
  input  logic signed [WIDTH-1:0] i_real,
  input  logic signed [WIDTH-1:0] i_imag,
  output logic [BINS*OUT_W-1:0]   o_levels,
  output logic                    o_frame_valid,
  output logic                    o_frame_err
);

  localparam int IDX_W = $clog2(BINS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BINS - 1);
  localparam logic [OUT_W-1:0] DEC_V = OUT_W'(DECAY);

  state_t           r_state;
  state_t           w_state_n;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_n;
  logic             w_cap;
  logic [IDX_W-1:0] w_cap_idx;
  logic             w_cap_last;
  logic             w_abort;

  logic             w_s2_v;
  logic [IDX_W-1:0] w_s2_idx;
  logic             w_s2_last;
  logic [OUT_W-1:0] w_s2_lvl;

  logic [OUT_W-1:0] r_shadow [2][BINS];
  logic             r_wbank;
  logic             r_pub;
  logic [OUT_W-1:0] r_held [BINS];
  logic [OUT_W-1:0] w_held_n [BINS];
  logic [OUT_W-1:0] w_dec [BINS];
  logic [OUT_W-1:0] w_rd [BINS];
  logic             r_fv;
  logic             r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_idx_n    = r_idx;
    w_cap      = 1'b0;
    w_cap_idx  = '0;
    w_cap_last = 1'b0;
    w_abort    = 1'b0;
    unique case (r_state)
      IDLE, SKIP: begin
        if (i_ce && i_sync) begin
          w_cap     = 1'b1;
          w_state_n = CAPTURE;
          w_idx_n   = IDX_W'(1);
        end
      end
      CAPTURE: begin
        if (i_ce) begin
          w_cap = 1'b1;
          if (i_sync) begin
            w_abort = 1'b1;
            w_idx_n = IDX_W'(1);
          end else begin
            w_cap_idx = r_idx;
            if (r_idx == LAST_IDX) begin
              w_cap_last = 1'b1;
              w_state_n  = SKIP;
              w_idx_n    = '0;
            end else begin
              w_idx_n = r_idx + IDX_W'(1);
            end
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  bin_energy_sat #(
    .WIDTH (WIDTH),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W),
    .IDX_W (IDX_W)
  ) u_energy (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (w_abort),
    .i_valid (w_cap),
    .i_idx   (w_cap_idx),
    .i_last  (w_cap_last),
    .i_real  (i_real),
    .i_imag  (i_imag),
    .o_valid (w_s2_v),
    .o_idx   (w_s2_idx),
    .o_last  (w_s2_last),
    .o_lvl   (w_s2_lvl)
  );

  // The completed bank is ~r_wbank once its last bin has landed.
  always_comb begin
    for (int b = 0; b < BINS; b++) begin
      w_rd[b]  = r_shadow[~r_wbank][b];
      w_dec[b] = (r_held[b] > DEC_V) ? r_held[b] - DEC_V : '0;
      w_held_n[b] = (w_rd[b] > w_dec[b]) ? w_rd[b] : w_dec[b];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int b = 0; b < BINS; b++) begin
          r_shadow[k][b] <= '0;
        end
      end
      for (int b = 0; b < BINS; b++) begin
        r_held[b] <= '0;
      end
      r_wbank <= 1'b0;
      r_pub   <= 1'b0;
      r_fv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_pub <= 1'b0;
      if (w_s2_v) begin
        r_shadow[r_wbank][w_s2_idx] <= w_s2_lvl;
        if (w_s2_last) begin
          r_wbank <= ~r_wbank;
          r_pub   <= 1'b1;
        end
      end
      if (r_pub) begin
        for (int b = 0; b < BINS; b++) begin
          r_held[b] <= w_held_n[b];
        end
      end
      r_fv  <= r_pub;
      r_err <= w_abort;
    end
  end

  for (genvar g = 0; g < BINS; g++) begin : g_out
    assign o_levels[g*OUT_W +: OUT_W] = r_held[g];
  end

  assign o_frame_valid = r_fv;
  assign o_frame_err   = r_err;

endmodule

// File: tb/tb_fft_bin_sequencer.sv
// Randomized bench for fft_bin_sequencer against a frame-level
// reference model of capture, energy, peak-hold and publish timing.
module tb_fft_bin_sequencer;

  localparam int WIDTH = 12;
  localparam int BINS  = 8;
  localparam int SHIFT = 6;
  localparam int OUT_W = 8;
  localparam int DECAY = 4;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    i_ce = 1'b0;
  logic                    i_sync = 1'b0;
  logic signed [WIDTH-1:0] i_real = '0;
  logic signed [WIDTH-1:0] i_imag = '0;
  logic [BINS*OUT_W-1:0]   o_levels;
  logic                    o_frame_valid;
  logic                    o_frame_err;

  always #5 clk = ~clk;

  fft_bin_sequencer #(
    .WIDTH (WIDTH),
    .BINS  (BINS),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W),
    .DECAY (DECAY)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_ce          (i_ce),
    .i_sync        (i_sync),
    .i_real        (i_real),
    .i_imag        (i_imag),
    .o_levels      (o_levels),
    .o_frame_valid (o_frame_valid),
    .o_frame_err   (o_frame_err)
  );

  typedef struct {
    int          p;
    logic [63:0] lv;
  } pub_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   pcount  = 0;
  int   held [BINS];
  int   cap  [BINS];
  bit   capturing = 1'b0;
  int   ncap = 0;
  pub_t pub_q [$];
  int   err_q [$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int energy(input logic signed [WIDTH-1:0] re,
                                input logic signed [WIDTH-1:0] im);
    int e;
    e = (int'(re) * int'(re) + int'(im) * int'(im)) >> SHIFT;
    return (e > 255) ? 255 : e;
  endfunction

  task automatic model_sample(input bit sync,
                              input logic signed [WIDTH-1:0] re,
                              input logic signed [WIDTH-1:0] im,
                              input int p);
    logic [63:0] lv;
    int d;
    if (sync) begin
      if (capturing) err_q.push_back(p);
      capturing = 1'b1;
      ncap = 0;
    end
    if (capturing) begin
      cap[ncap] = energy(re, im);
      ncap++;
      if (ncap == BINS) begin
        lv = '0;
        for (int b = 0; b < BINS; b++) begin
          d = held[b] - DECAY;
          if (d < 0) d = 0;
          held[b] = (cap[b] > d) ? cap[b] : d;
          lv[b*OUT_W +: OUT_W] = OUT_W'(held[b]);
        end
        pub_q.push_back('{p + 3, lv});
        capturing = 1'b0;
      end
    end
  endtask

  task automatic cyc(input bit ce, input bit sync,
                     input logic signed [WIDTH-1:0] re,
                     input logic signed [WIDTH-1:0] im);
    bit ev;
    bit ee;
    i_ce = ce;
    i_sync = sync;
    i_real = re;
    i_imag = im;
    if (ce) model_sample(sync, re, im, pcount + 1);
    @(posedge clk);
    pcount++;
    @(negedge clk);
    ev = (pub_q.size() > 0) && (pub_q[0].p == pcount);
    check("frame_valid", 64'(o_frame_valid), 64'(ev));
    if (ev) begin
      check("levels", o_levels, pub_q[0].lv);
      void'(pub_q.pop_front());
    end
    ee = (err_q.size() > 0) && (err_q[0] == pcount);
    check("frame_err", 64'(o_frame_err), 64'(ee));
    if (ee) void'(err_q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0);
  endtask

  task automatic send_frame(input logic signed [WIDTH-1:0] re [BINS],
                            input logic signed [WIDTH-1:0] im [BINS]);
    for (int b = 0; b < BINS; b++) cyc(1'b1, b == 0, re[b], im[b]);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_levels", o_levels, 64'd0);
    check("rst_valid", 64'(o_frame_valid), 64'd0);
    check("rst_err", 64'(o_frame_err), 64'd0);
    capturing = 1'b0;
    ncap = 0;
    for (int b = 0; b < BINS; b++) held[b] = 0;
    pub_q.delete();
    err_q.delete();
    i_ce = 1'b0;
    i_sync = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic signed [WIDTH-1:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return WIDTH'($urandom);
    return WIDTH'(int'($urandom_range(0, 160)) - 80);
  endfunction

  logic signed [WIDTH-1:0] fr [BINS];
  logic signed [WIDTH-1:0] fi [BINS];
  int pos;
  int flen;
  bit ce;
  bit sy;

  initial begin
    for (int b = 0; b < BINS; b++) held[b] = 0;
    #1;
    check("init_levels", o_levels, 64'd0);
    check("init_valid", 64'(o_frame_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // mid-stream reset with a publish in flight
    for (int b = 0; b < BINS; b++) begin
      fr[b] = 12'sd50;
      fi[b] = 12'sd20;
    end
    send_frame(fr, fi);
    do_reset();
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, rnd_val(), rnd_val());
    check("t1_no_pub", o_levels, 64'd0);

    // single tone in bin 3
    for (int b = 0; b < BINS; b++) begin
      fr[b] = '0;
      fi[b] = '0;
    end
    fr[3] = 12'sd64;
    send_frame(fr, fi);
    idle(4);
    check("t2_lvl3", 64'(o_levels[31:24]), 64'd64);
    check("t2_rest", o_levels & ~64'hFF00_0000, 64'd0);

    // saturation at the most negative input
    do_reset();
    fr[3] = '0;
    fr[0] = -12'sd2048;
    fi[0] = -12'sd2048;
    send_frame(fr, fi);
    idle(4);
    check("t3_lvl0", 64'(o_levels[7:0]), 64'd255);

    // short frame then a full frame
    do_reset();
    fr[0] = '0;
    fi[0] = '0;
    for (int b = 0; b < 5; b++) cyc(1'b1, b == 0, 12'sd100, 12'sd0);
    fr[1] = 12'sd64;
    send_frame(fr, fi);
    idle(4);
    check("t4_lvl1", 64'(o_levels[15:8]), 64'd64);
    check("t4_rest", o_levels & ~64'h0000_FF00, 64'd0);

    // peak-hold decay
    do_reset();
    fr[1] = '0;
    fr[5] = 12'sd80;
    send_frame(fr, fi);
    idle(4);
    check("t5_hold0", 64'(o_levels[47:40]), 64'd100);
    fr[5] = '0;
    send_frame(fr, fi);
    idle(4);
    check("t5_hold1", 64'(o_levels[47:40]), 64'd96);
    send_frame(fr, fi);
    idle(4);
    check("t5_hold2", 64'(o_levels[47:40]), 64'd92);

    // back-to-back frames, FFT length equal to BINS
    for (int f = 0; f < 6; f++) begin
      for (int b = 0; b < BINS; b++) begin
        fr[b] = rnd_val();
        fi[b] = rnd_val();
      end
      send_frame(fr, fi);
    end
    idle(5);

    // random strobes, frame lengths and early syncs
    pos = 0;
    flen = 8;
    for (int i = 0; i < 3000; i++) begin
      ce = ($urandom_range(0, 2) != 0);
      sy = 1'b0;
      if (ce) begin
        sy = (pos == 0) || ($urandom_range(0, 39) == 0);
        if (sy) begin
          pos = 0;
          flen = $urandom_range(8, 12);
        end
        pos = (pos + 1) % flen;
      end
      cyc(ce, sy, rnd_val(), rnd_val());
    end
    idle(5);
    check("end_pending", 64'(pub_q.size() + err_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
